// File: rtl/hsaf_pkg.sv
// Shared types and constants for the spline adaptive filter coefficient reader.
// HSAF_COEF_CHKSUM_EN adds the trailing checksum state to the dump FSM.
package hsaf_pkg;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;
    localparam int         SEQ_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        HEADER,
        LIN,
        QA,
        QD
`ifdef HSAF_COEF_CHKSUM_EN
        ,
        CSUM
`endif
    } state_t;

endpackage

// File: rtl/hsaf_stream_out.sv
// Output register of the coefficient dump stream. Owns m_valid/m_data/m_last.
// A bypass load presents the q-table read data directly in its first valid
// cycle and captures it, so the word is held while backpressured.
module hsaf_stream_out #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             ld_byp,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_last,
    input  logic [WIDTH-1:0] byp_data,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    output logic             m_last
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             byp_q, byp_d;

    // Register next-state: capture bypass data, retire on transfer, then load.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        byp_d   = byp_q;
        if (valid_q && byp_q) begin
            data_d = byp_data;
            byp_d  = 1'b0;
        end
        if (valid_q && m_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
        if (load) begin
            data_d  = ld_data;
            valid_d = 1'b1;
            last_d  = ld_last;
            byp_d   = ld_byp;
        end
    end

    // Output register state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            byp_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            byp_q   <= byp_d;
        end
    end

    assign m_data  = byp_q ? byp_data : data_q;
    assign m_valid = valid_q;
    assign m_last  = last_q;

endmodule

// File: rtl/hsaf_coef_reader.sv
// Coefficient dump engine: snapshots the linear FIR weights, walks the q-weight
// table and streams header / weights / q-points (/ checksum) as one frame while
// holding weight updates via freeze.
// HSAF_COEF_CHKSUM_EN: append a wrap-around checksum word as the final word.
module hsaf_coef_reader
    import hsaf_pkg::*;
#(
    parameter int L_ORD = 32,
    parameter int Q     = 13,
    parameter int WIDTH = 16,
    parameter int QA_W  = $clog2(Q)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               freeze,
    input  logic [L_ORD*WIDTH-1:0] lin_w,
    output logic               q_rd,
    output logic [QA_W-1:0]    q_addr,
    input  logic [WIDTH-1:0]   q_rdata,
    output logic [WIDTH-1:0]   m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last
);

    localparam int LI_W = (L_ORD > 1) ? $clog2(L_ORD) : 1;

    state_t           state_q, state_d;
    logic [LI_W-1:0]  i_q, i_d;
    logic [QA_W-1:0]  k_q, k_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             freeze_q, freeze_d;
    logic [WIDTH-1:0] snap_q [L_ORD];
    logic [WIDTH-1:0] snap_d [L_ORD];
`ifdef HSAF_COEF_CHKSUM_EN
    logic [WIDTH-1:0] csum_q, csum_d;
`endif

    logic             xfer, lin_end, q_end, frame_done;
    logic             so_load, so_byp, so_last;
    logic [WIDTH-1:0] so_data;

    assign xfer    = m_valid & m_ready;
    assign lin_end = (i_q == LI_W'(L_ORD - 1));
    assign q_end   = (k_q == QA_W'(Q - 1));
`ifdef HSAF_COEF_CHKSUM_EN
    assign frame_done = (state_q == CSUM) && xfer;
`else
    assign frame_done = (state_q == QD) && q_end && xfer;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: LIN streams back-to-back, q words alternate read / present.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CAPTURE;
            CAPTURE: state_d = HEADER;
            HEADER:  if (xfer) state_d = LIN;
            LIN:     if (xfer && lin_end) state_d = QA;
            QA:      state_d = QD;
            QD: begin
                if (xfer) begin
`ifdef HSAF_COEF_CHKSUM_EN
                    state_d = q_end ? CSUM : QA;
`else
                    state_d = q_end ? IDLE : QA;
`endif
                end
            end
`ifdef HSAF_COEF_CHKSUM_EN
            CSUM:    if (xfer) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: q-table strobe and the next word loaded into the stream register.
    always_comb begin
        q_rd    = 1'b0;
        so_load = 1'b0;
        so_byp  = 1'b0;
        so_last = 1'b0;
        so_data = '0;
        unique case (state_q)
            CAPTURE: begin
                so_load = 1'b1;
                so_data = WIDTH'({HDR_MAGIC, seq_q});
            end
            HEADER: begin
                so_load = xfer;
                so_data = snap_q[0];
            end
            LIN: begin
                so_load = xfer && !lin_end;
                so_data = snap_q[i_q + LI_W'(1)];
            end
            QA: begin
                q_rd    = 1'b1;
                so_load = 1'b1;
                so_byp  = 1'b1;
`ifndef HSAF_COEF_CHKSUM_EN
                so_last = q_end;
`endif
            end
`ifdef HSAF_COEF_CHKSUM_EN
            CSUM: begin
                so_load = !m_valid;
                so_last = 1'b1;
                so_data = csum_q;
            end
`endif
            default: ;
        endcase
    end

    // Datapath next-state: snapshot, indices, freeze, checksum and frame counter.
    always_comb begin
        i_d      = i_q;
        k_d      = k_q;
        seq_d    = seq_q;
        freeze_d = freeze_q;
`ifdef HSAF_COEF_CHKSUM_EN
        csum_d   = csum_q;
`endif
        for (int j = 0; j < L_ORD; j++) begin
            snap_d[j] = (state_q == CAPTURE) ? lin_w[WIDTH*j +: WIDTH] : snap_q[j];
        end
        unique case (state_q)
            CAPTURE: begin
                freeze_d = 1'b1;
                i_d      = '0;
                k_d      = '0;
`ifdef HSAF_COEF_CHKSUM_EN
                csum_d   = '0;
`endif
            end
            LIN: begin
                if (xfer) begin
                    if (!lin_end) i_d = i_q + LI_W'(1);
`ifdef HSAF_COEF_CHKSUM_EN
                    csum_d = csum_q + m_data;
`endif
                end
            end
            QD: begin
                // Last q word is in the output register: updates may resume.
                if (q_end) freeze_d = 1'b0;
                if (xfer) begin
                    if (!q_end) k_d = k_q + QA_W'(1);
`ifdef HSAF_COEF_CHKSUM_EN
                    csum_d = csum_q + m_data;
`endif
                end
            end
            default: ;
        endcase
        if (frame_done) seq_d = seq_q + SEQ_W'(1);
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            i_q      <= '0;
            k_q      <= '0;
            seq_q    <= '0;
            freeze_q <= 1'b0;
`ifdef HSAF_COEF_CHKSUM_EN
            csum_q   <= '0;
`endif
            for (int j = 0; j < L_ORD; j++) snap_q[j] <= '0;
        end else begin
            i_q      <= i_d;
            k_q      <= k_d;
            seq_q    <= seq_d;
            freeze_q <= freeze_d;
`ifdef HSAF_COEF_CHKSUM_EN
            csum_q   <= csum_d;
`endif
            for (int j = 0; j < L_ORD; j++) snap_q[j] <= snap_d[j];
        end
    end

    assign busy   = (state_q != IDLE);
    assign freeze = freeze_q;
    assign q_addr = k_q;

    hsaf_stream_out #(.WIDTH(WIDTH)) u_out (
        .clk      (clk),
        .reset    (reset),
        .load     (so_load),
        .ld_byp   (so_byp),
        .ld_data  (so_data),
        .ld_last  (so_last),
        .byp_data (q_rdata),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_last   (m_last)
    );

endmodule

// File: tb/tb_hsaf_coef_reader.sv
// Bench for hsaf_coef_reader with L_ORD=4, Q=4, WIDTH=16. A frame-level model
// (expected word queue built at start time, nominal cycle per word) is checked
// on every transfer and every frame cycle; literal tables pin the model.
module tb_hsaf_coef_reader;

    localparam int L = 4;
    localparam int Q = 4;
    localparam int W = 16;
`ifdef HSAF_COEF_CHKSUM_EN
    localparam int FLEN    = L + Q + 2;
    localparam bit CSUM_ON = 1'b1;
`else
    localparam int FLEN    = L + Q + 1;
    localparam bit CSUM_ON = 1'b0;
`endif
    localparam int FRZ_END = L + 4 + 2 * (Q - 1);

    logic           clk = 1'b0;
    logic           reset, start, m_ready;
    logic [L*W-1:0] lin_w;
    logic           busy, freeze, q_rd, m_valid, m_last;
    logic [1:0]     q_addr;
    logic [W-1:0]   q_rdata, m_data;
    logic [W-1:0]   qmem [Q];
    logic [W-1:0]   basic_ref [10];

    int n_cmp = 0;
    int n_err = 0;

    // model / monitor state
    int         cyc = 0, t0 = 0, w_idx = 0, c = 0;
    bit         act = 1'b0, tmode = 1'b1, pend = 1'b0;
    logic [W-1:0] pd;
    logic       pl;
    logic [7:0] seq_m = 8'd0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] log_q [$];

    always #5 clk = ~clk;

    hsaf_coef_reader #(.L_ORD(L), .Q(Q), .WIDTH(W), .QA_W(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .freeze  (freeze),
        .lin_w   (lin_w),
        .q_rd    (q_rd),
        .q_addr  (q_addr),
        .q_rdata (q_rdata),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last)
    );

    // q-weight table: registered read, data one cycle after the strobe
    always @(posedge clk) if (q_rd) q_rdata <= qmem[q_addr];

    function automatic void check(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
        end
    endfunction

    // nominal cycle (relative to start) of frame word w with m_ready held high
    function automatic int exp_cyc(input int w);
        if (w == 0) return 2;
        if (w <= L) return 2 + w;
        if (w <= L + Q) return L + 4 + 2 * (w - L - 1);
        return L + 4 + 2 * Q;
    endfunction

    function automatic void build_frame();
        logic [W-1:0] s = '0;
        logic [W-1:0] v;
        exp_q.push_back({8'hA5, seq_m});
        for (int j = 0; j < L; j++) begin
            v = lin_w[W*j +: W];
            s = s + v;
            exp_q.push_back(v);
        end
        for (int k = 0; k < Q; k++) begin
            s = s + qmem[k];
            exp_q.push_back(qmem[k]);
        end
        if (CSUM_ON) exp_q.push_back(s);
    endfunction

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        logic [W-1:0] e;
        cyc++;
        if (!reset) begin
            exp_q.delete();
            seq_m = 8'd0;
            w_idx = 0;
            act   = 1'b0;
            pend  = 1'b0;
        end else begin
            if (act && tmode) begin
                c = cyc - t0;
                check("busy", busy, (c >= 1 && c <= exp_cyc(FLEN - 1)) ? 1 : 0);
                check("freeze", freeze, (c >= 2 && c <= FRZ_END) ? 1 : 0);
                if (c > exp_cyc(FLEN - 1)) act = 1'b0;
            end
            if (q_rd) check("q_rd while word pending", m_valid, 0);
            if (pend) begin
                check("hold valid", m_valid, 1);
                check("hold data", m_data, pd);
                check("hold last", m_last, pl);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected transfer: got %0h expected none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("data w%0d", w_idx), m_data, e);
                    check($sformatf("last w%0d", w_idx), m_last, (w_idx == FLEN - 1) ? 1 : 0);
                    if (tmode) check($sformatf("cycle w%0d", w_idx), cyc - t0, exp_cyc(w_idx));
                end
                log_q.push_back(m_data);
                if (w_idx == FLEN - 1) begin
                    seq_m = seq_m + 8'd1;
                    w_idx = 0;
                end else begin
                    w_idx++;
                end
            end
            pend = m_valid && !m_ready;
            pd   = m_data;
            pl   = m_last;
            if (start && !busy) begin
                build_frame();
                t0  = cyc;
                act = 1'b1;
            end
        end
    end

    task automatic wait_idle(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 2000);
        check({nm, " done"}, busy, 0);
    endtask

    task automatic run_frame(input string nm);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle(nm);
    endtask

    task automatic hdr_check(input string nm, input logic [W-1:0] e);
        if (log_q.size() > 0) check(nm, log_q[0], e);
        else check({nm, " present"}, 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        basic_ref = '{16'hA500, 16'h1, 16'h2, 16'h3, 16'h4,
                      16'h10, 16'h11, 16'h12, 16'h13, 16'h50};
        for (int k = 0; k < Q; k++) qmem[k] = 16'h10 + W'(k);
        lin_w   = {16'h4, 16'h3, 16'h2, 16'h1};
        reset   = 1'b0;
        start   = 1'b0;
        m_ready = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", busy, 0);
        check("rst freeze", freeze, 0);
        check("rst q_rd", q_rd, 0);
        check("rst q_addr", q_addr, 0);
        check("rst m_valid", m_valid, 0);
        check("rst m_data", m_data, 0);
        check("rst m_last", m_last, 0);
        @(posedge clk); #1 reset = 1'b1;

        // basic frame
        log_q.delete();
        run_frame("basic");
        check("basic len", log_q.size(), FLEN);
        for (int i = 0; i < FLEN; i++)
            if (i < log_q.size()) check($sformatf("basic ref w%0d", i), log_q[i], basic_ref[i]);

        // snapshot coherence: weights change after capture
        log_q.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 lin_w = '1;
        wait_idle("snap");
        hdr_check("snap hdr seq1", 16'hA501);
        for (int i = 1; i <= L; i++)
            if (i < log_q.size()) check($sformatf("snap w%0d", i), log_q[i], basic_ref[i]);
        lin_w = {16'h4, 16'h3, 16'h2, 16'h1};

        // backpressure: m_ready toggles every cycle
        tmode = 1'b0;
        log_q.delete();
        for (int n = 0; n < 600; n++) begin
            @(posedge clk); #1;
            m_ready = ~m_ready;
            start   = (n == 0);
            @(negedge clk);
            if (n > 1 && !busy) break;
        end
        check("bp done", busy, 0);
        @(posedge clk); #1 m_ready = 1'b1;
        tmode = 1'b1;
        hdr_check("bp hdr", 16'hA502);
        check("bp len", log_q.size(), FLEN);
        for (int i = 1; i < FLEN; i++)
            if (i < log_q.size()) check($sformatf("bp w%0d", i), log_q[i], basic_ref[i]);

        // start held high through a frame
        log_q.delete();
        @(posedge clk); #1 start = 1'b1;
        begin
            int  n = 0;
            bit  seen = 1'b0;
            while (n < 600) begin
                @(negedge clk);
                n++;
                if (busy) seen = 1'b1;
                else if (seen) break;
            end
        end
        check("ign first end", busy, 0);
        check("ign one frame", log_q.size(), FLEN);
        @(posedge clk); #1 start = 1'b0;
        wait_idle("ign");
        check("ign two frames", log_q.size(), 2 * FLEN);
        hdr_check("ign hdr1", 16'hA503);
        if (log_q.size() > FLEN) check("ign hdr2", log_q[FLEN], 16'hA504);

        // reset while LIN index 2 is presented
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst-mid at lin2", m_data, 16'h3);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("rst-mid m_valid", m_valid, 0);
        check("rst-mid freeze", freeze, 0);
        check("rst-mid busy", busy, 0);
        check("rst-mid m_last", m_last, 0);
        check("rst-mid q_rd", q_rd, 0);
        log_q.delete();
        run_frame("post-rst");
        hdr_check("post-rst hdr", 16'hA500);

        // seq wrap across 256 frames from a clean reset
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        for (int f = 0; f < 255; f++) run_frame("wrap");
        log_q.delete();
        run_frame("wrap255");
        hdr_check("wrap hdr ff", 16'hA5FF);
        log_q.delete();
        run_frame("wrap256");
        hdr_check("wrap hdr 00", 16'hA500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hsaf_coef_reader.md
# hsaf_coef_reader

Host-side readback engine for the spline adaptive filter. On a start request it snapshots the linear FIR weights and reads every spline control point from the q-weight table, then emits one framed coefficient dump over a valid/ready stream. It is the reader that pairs with the weight-update writers, and it sits beside the filter top. A `freeze` output holds weight updates while the dump is in flight, so the frame is coherent.

## Interface
Parameters:
- L_ORD, 32, number of linear FIR weights
- Q, 13, number of spline control points in the q-weight table
- WIDTH, 16, coefficient word width; must be ≥ 16
- QA_W, $clog2(Q), q-table address width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  single-cycle dump request
- busy  out  1  frame in progress
- freeze  out  1  weight-update hold to the filter datapath
- lin_w  in  L_ORD*WIDTH  packed linear weights; word i is at [WIDTH*i +: WIDTH]
- q_rd  out  1  q-table read strobe
- q_addr  out  QA_W  q-table read address
- q_rdata  in  WIDTH  q-table data, valid one cycle after q_rd
- m_data  out  WIDTH  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- m_last  out  1  final word of frame

## Operation
- FSM states: IDLE, CAPTURE, HEADER, LIN, QA, QD, CSUM.
- IDLE:
  - start=1 → CAPTURE.
  - start is ignored in every other state, including the cycle of the final transfer.
- CAPTURE (1 cycle):
  - latch lin_w into the internal snapshot bank
  - set freeze=1, clear the checksum accumulator → HEADER
- HEADER:
  - load m_data = {0xA5 in bits [15:8] zero-extended to WIDTH-8 bits, seq[7:0]}
  - on transfer → LIN with index 0
- LIN:
  - present snapshot word i
  - on transfer, i++; after i = L_ORD-1 → QA with k = 0
- QA (1 cycle):
  - q_rd=1, q_addr=k, m_valid=0 → QD
- QD:
  - capture q_rdata into the output register, m_valid=1
  - on transfer: k++ → QA, or after k = Q-1 → CSUM (or IDLE without the macro)
  - freeze drops to 0 in the cycle after the last q_rdata is captured
- CSUM: present the checksum word → IDLE on transfer.
- Checksum: WIDTH-bit wrap-around sum of all LIN and QD payload words; the header is excluded.
- seq: 8-bit frame counter; increments on each frame's final transfer; wraps 255→0.
- Handshake:
  - a transfer occurs when m_valid & m_ready
  - m_data and m_last are held stable while m_valid=1 and m_ready=0
  - m_valid never drops without a transfer
- m_last=1 only on the final word of the frame.
- busy=1 from CAPTURE until the cycle after the final transfer.

## Timing
- Reset values: busy=0, freeze=0, q_rd=0, q_addr=0, m_valid=0, m_data=0, m_last=0, seq=0, state IDLE.
- Timing below assumes start sampled at cycle 0 and m_ready held at 1:
  - CAPTURE at cycle 1; freeze=1 from cycle 2
  - header valid at cycle 2
  - lin word i valid at cycle 3+i
  - q word k valid at cycle L_ORD+4+2k
  - checksum valid at cycle L_ORD+4+2Q
- QA/QD throughput is one word per 2 cycles; LIN throughput is one word per cycle.
- Backpressure stalls only the current state. A q read is not reissued while the QD word is unaccepted.
- reset=0 mid-frame: the frame is abandoned. All outputs return to reset values at the next edge, with no partial m_last, and seq is cleared.

## Configuration
- HSAF_COEF_CHKSUM_EN defined:
  - CSUM state is present
  - frame length is L_ORD+Q+2 words; m_last is on the checksum word
- Not defined:
  - no CSUM state or accumulator
  - frame length is L_ORD+Q+1 words; m_last is on q word Q-1

## Structure
- Shared package hsaf_pkg holds:
  - the state enum type
  - HDR_MAGIC = 8'hA5
  - SEQ_W = 8
- Sub-module hsaf_stream_out: single output register with load/hold/valid/last handling. The FSM drives its load enable and data; it owns m_valid, m_data and m_last.

## Test plan
Parameters for all tests: L_ORD=4, Q=4, WIDTH=16, macro defined, unless stated otherwise.
- Basic frame:
  - stimulus: lin_w = {0x0004,0x0003,0x0002,0x0001}, q table 0x0010..0x0013, m_ready=1, start pulse
  - response: words 0xA500, 1, 2, 3, 4, 0x10, 0x11, 0x12, 0x13, checksum 0x0050 with m_last; seq=1 afterwards
- Snapshot coherence: lin_w changes to all-0xFFFF at cycle 2 → the dump still carries 1, 2, 3, 4.
- Backpressure: m_ready toggles 1/0 each cycle → identical word sequence; m_data is stable whenever valid&!ready; no q_rd is issued while a QD word is pending.
- Ignored start: start pulses every cycle during a frame → exactly one frame; the second frame begins only after busy falls.
- Reset mid-frame: reset=0 while the LIN index is 2 → next cycle m_valid=0, freeze=0, busy=0; the next frame header is 0xA500.
- Macro off with seq wrap:
  - first 255 frames: q words valid at cycles 8, 10, 12, 14; the frame ends on q word 3 with m_last
  - 256th frame: header 0xA5FF, and seq wraps to 0 after it
